// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: launches the external multiplier or divider,
// stalls the pipeline until the result is captured, then presents it for write-back.
// Optional build macro MD_ZERO_SKIP_EN short-circuits multiplies by a zero operand.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module md_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`StallBus]  stall,
  input  logic              flush,
  input  logic [3:0]        ex_md_op,
  input  logic [31:0]       ex_src_a,
  input  logic [31:0]       ex_src_b,
  output logic              md_stallreq,
  output logic              mul_start,
  output logic              div_start,
  output logic              mul_signed,
  output logic              div_signed,
  output logic [31:0]       md_op_a,
  output logic [31:0]       md_op_b,
  input  logic [63:0]       mul_result,
  input  logic              div_ready,
  input  logic [31:0]       div_quot,
  input  logic [31:0]       div_rem,
  output logic              div_cancel,
  output logic              hi_we,
  output logic              lo_we,
  output logic [31:0]       hi_wdata,
  output logic [31:0]       lo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
  logic        mul_sgn_q, div_sgn_q;
  logic        is_div, is_divu, is_mult, is_multu, is_mul_op, is_div_op, op_valid;
  logic        launch, div_zero, mul_zero, done;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // Only a clean one-hot encoding counts as an operation.
  assign is_div    = (ex_md_op == 4'b1000);
  assign is_divu   = (ex_md_op == 4'b0100);
  assign is_mult   = (ex_md_op == 4'b0010);
  assign is_multu  = (ex_md_op == 4'b0001);
  assign is_mul_op = is_mult | is_multu;
  assign is_div_op = is_div | is_divu;
  assign op_valid  = is_mul_op | is_div_op;

  assign launch   = !rst && (state == IDLE) && op_valid && !flush;
  assign div_zero = is_div_op && (ex_src_b == 32'd0);
`ifdef MD_ZERO_SKIP_EN
  assign mul_zero = is_mul_op && ((ex_src_a == 32'd0) || (ex_src_b == 32'd0));
`else
  assign mul_zero = 1'b0;
`endif

  assign mul_start = launch && is_mul_op && !mul_zero;
  assign div_start = launch && is_div_op && !div_zero;

  // Units see the live operands during the start pulse, the latched copy afterwards.
  assign md_op_a    = launch ? ex_src_a : op_a_q;
  assign md_op_b    = launch ? ex_src_b : op_b_q;
  assign mul_signed = launch ? is_mult  : mul_sgn_q;
  assign div_signed = launch ? is_div   : div_sgn_q;

  assign md_stallreq = !rst && (((state == IDLE) && op_valid) ||
                                (state == MUL_WAIT) || (state == DIV_WAIT));
  assign div_cancel  = !rst && flush && (state == DIV_WAIT);

  assign done     = !rst && (state == DONE);
  assign hi_we    = done;
  assign lo_we    = done;
  assign hi_wdata = done ? hi_q : 32'd0;
  assign lo_wdata = done ? lo_q : 32'd0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      hi_nxt    = 32'd0;
      lo_nxt    = 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mul_start) begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = 4'(MUL_LAT);
          end else if (div_start) begin
            state_nxt = DIV_WAIT;
          end else if (launch && div_zero) begin
            state_nxt = DONE;
            hi_nxt    = ex_src_a;
            lo_nxt    = 32'hFFFF_FFFF;
          end else if (launch) begin
            state_nxt = DONE;
            hi_nxt    = 32'd0;
            lo_nxt    = 32'd0;
          end
        end
        MUL_WAIT: begin
          // The product is valid in the cycle the count steps down to zero.
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            cnt_nxt   = 4'd0;
            hi_nxt    = mul_result[63:32];
            lo_nxt    = mul_result[31:0];
            state_nxt = DONE;
          end
        end
        DIV_WAIT: begin
          if (div_ready) begin
            hi_nxt    = div_rem;
            lo_nxt    = div_quot;
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (stall[3] == `NoStop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mul_sgn_q <= 1'b0;
      div_sgn_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      if (launch) begin
        op_a_q    <= ex_src_a;
        op_b_q    <= ex_src_b;
        mul_sgn_q <= is_mult;
        div_sgn_q <= is_div;
      end
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected HI/LO pairs, a monitor
// pops and compares them whenever the scheduler presents a write-back.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module tb_md_sched;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst, flush, div_ready;
  logic [`StallBus] stall;
  logic [3:0]  ex_md_op;
  logic [31:0] ex_src_a, ex_src_b, div_quot, div_rem;
  logic        md_stallreq, mul_start, div_start, mul_signed, div_signed, div_cancel;
  logic [31:0] md_op_a, md_op_b, hi_wdata, lo_wdata;
  logic [63:0] mul_result;
  logic        hi_we, lo_we;

  int checks = 0;
  int failures = 0;

  md_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_md_op(ex_md_op),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .md_stallreq(md_stallreq),
    .mul_start(mul_start), .div_start(div_start), .mul_signed(mul_signed),
    .div_signed(div_signed), .md_op_a(md_op_a), .md_op_b(md_op_b),
    .mul_result(mul_result), .div_ready(div_ready), .div_quot(div_quot),
    .div_rem(div_rem), .div_cancel(div_cancel), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Multiplier model: product is presented only on the cycle MUL_LAT after mul_start.
  logic [63:0] pend = 64'd0;
  int          mcnt = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      pend <= mul_signed ? ({{32{md_op_a[31]}}, md_op_a} * {{32{md_op_b[31]}}, md_op_b})
                         : ({32'd0, md_op_a} * {32'd0, md_op_b});
      mcnt <= 1;
    end else if (mcnt != 0 && mcnt < 15) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_result = (mcnt == MUL_LAT) ? pend : 64'hDEAD_BEEF_0BAD_F00D;

  // Scoreboard monitor.
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp = 64'd0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    automatic logic [63:0] e = cur_exp;
    if (!rst) begin
      chk("lo_we_tracks_hi_we", {63'd0, lo_we}, {63'd0, hi_we});
      if (hi_we) begin
        if (!prev_we) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_writeback actual hi=%0h lo=%0h required no write", hi_wdata, lo_wdata);
          end else begin
            e = exp_q.pop_front();
          end
          cur_exp <= e;
        end
        chk("hi_wdata", {32'd0, hi_wdata}, {32'd0, e[63:32]});
        chk("lo_wdata", {32'd0, lo_wdata}, {32'd0, e[31:0]});
      end else begin
        chk("idle_wdata_zero", {hi_wdata, lo_wdata}, 64'd0);
      end
    end
    prev_we <= hi_we && !rst;
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ready_at, input logic [31:0] q, input logic [31:0] r,
                        output int n_stall, output int n_mstart, output int n_dstart,
                        output int t_done, output logic sgn);
    ex_md_op = op; ex_src_a = a; ex_src_b = b;
    n_stall = 0; n_mstart = 0; n_dstart = 0; t_done = -1; sgn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      div_ready = (i == ready_at);
      div_quot  = (i == ready_at) ? q : 32'h0;
      div_rem   = (i == ready_at) ? r : 32'h0;
      @(negedge clk);
      n_stall  += int'(md_stallreq);
      n_mstart += int'(mul_start);
      n_dstart += int'(div_start);
      if (mul_start) sgn = mul_signed;
      if (div_start) sgn = div_signed;
      if (hi_we) begin
        t_done = i;
        break;
      end
      @(posedge clk); #1;
    end
    ex_md_op = 4'b0; div_ready = 1'b0; div_quot = 32'h0; div_rem = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nm, nd, td;
    logic sg;
    rst = 1'b1; flush = 1'b1; stall = '0; ex_md_op = 4'b0001;
    ex_src_a = 32'h1234; ex_src_b = 32'h5678;
    div_ready = 1'b0; div_quot = 32'h0; div_rem = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stallreq", {63'd0, md_stallreq}, 64'd0);
    chk("rst_mul_start", {63'd0, mul_start}, 64'd0);
    chk("rst_div_cancel", {63'd0, div_cancel}, 64'd0);
    chk("rst_hi_we", {63'd0, hi_we}, 64'd0);
    chk("rst_operands", {md_op_a, md_op_b}, 64'd0);
    chk("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; ex_md_op = 4'b0;
    @(negedge clk);
    chk("idle_stallreq", {63'd0, md_stallreq}, 64'd0);
    @(posedge clk); #1;

    // multu 0x10000 * 0x10000 = 1 << 32
    exp_q.push_back({32'h1, 32'h0});
    run_op(4'b0001, 32'h0001_0000, 32'h0001_0000, -1, 0, 0, ns, nm, nd, td, sg);
    chk("multu_mul_start_pulses", nm, 1);
    chk("multu_stall_cycles", ns, 3);
    chk("multu_done_cycle", td, 3);
    chk("multu_unsigned", {63'd0, sg}, 64'd0);
    @(posedge clk); #1;

    // mult -3 * 7 = -21
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(4'b0010, 32'hFFFF_FFFD, 32'd7, -1, 0, 0, ns, nm, nd, td, sg);
    chk("mult_mul_start_pulses", nm, 1);
    chk("mult_done_cycle", td, 3);
    chk("mult_signed", {63'd0, sg}, 64'd1);
    @(posedge clk); #1;

    // div -7 / 2 -> q=-3 r=-1, ready 10 cycles after launch, then held by stall
    stall[3] = `Stop;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(4'b1000, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFD, 32'hFFFF_FFFF, ns, nm, nd, td, sg);
    chk("div_div_start_pulses", nd, 1);
    chk("div_no_mul_start", nm, 0);
    chk("div_signed", {63'd0, sg}, 64'd1);
    chk("div_done_cycle", td, 11);
    chk("div_stall_cycles", ns, 11);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) ex_md_op = 4'b0001;
      if (k == 3) ex_md_op = 4'b0;
      @(negedge clk);
      chk("stop_hold_we", {63'd0, hi_we}, 64'd1);
      chk("done_no_launch", {63'd0, mul_start}, 64'd0);
      chk("done_stallreq", {63'd0, md_stallreq}, 64'd0);
    end
    @(posedge clk); #1;
    stall[3] = `NoStop;
    @(negedge clk);
    chk("release_cycle_we", {63'd0, hi_we}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_idle_we", {63'd0, hi_we}, 64'd0);
    @(posedge clk); #1;

    // divu 5 / 0
    exp_q.push_back({32'd5, 32'hFFFF_FFFF});
    run_op(4'b0100, 32'd5, 32'd0, -1, 0, 0, ns, nm, nd, td, sg);
    chk("div0_no_div_start", nd, 0);
    chk("div0_done_cycle", td, 1);
    chk("div0_stall_cycles", ns, 1);
    @(posedge clk); #1;

    // multi-hot op and stray div_ready in IDLE are ignored
    ex_md_op = 4'b0011; div_ready = 1'b1;
    @(negedge clk);
    chk("multihot_stallreq", {63'd0, md_stallreq}, 64'd0);
    chk("multihot_starts", {62'd0, mul_start, div_start}, 64'd0);
    @(posedge clk); #1;
    ex_md_op = 4'b0; div_ready = 1'b0;

    // flush coincident with launch
    ex_md_op = 4'b0001; ex_src_a = 32'd3; ex_src_b = 32'd4; flush = 1'b1;
    @(negedge clk);
    chk("flush_launch_no_start", {63'd0, mul_start}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; ex_md_op = 4'b0;
    @(negedge clk);
    chk("flush_launch_idle", {63'd0, md_stallreq}, 64'd0);
    chk("operand_reg_hold", {md_op_a, md_op_b}, {32'd5, 32'd0});
    @(posedge clk); #1;

    // flush in MUL_WAIT
    ex_md_op = 4'b0001; ex_src_a = 32'd2; ex_src_b = 32'd3;
    @(negedge clk);
    chk("mflush_start", {63'd0, mul_start}, 64'd1);
    @(posedge clk); #1;
    ex_md_op = 4'b0; flush = 1'b1;
    @(negedge clk);
    chk("mflush_no_cancel", {63'd0, div_cancel}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("mflush_idle", {63'd0, md_stallreq}, 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // flush in DIV_WAIT coincident with div_ready
    ex_md_op = 4'b1000; ex_src_a = 32'd100; ex_src_b = 32'd3;
    @(negedge clk);
    chk("dflush_start", {63'd0, div_start}, 64'd1);
    @(posedge clk); #1;
    ex_md_op = 4'b0;
    @(posedge clk); #1;
    flush = 1'b1; div_ready = 1'b1; div_quot = 32'd33; div_rem = 32'd1;
    @(negedge clk);
    chk("dflush_cancel", {63'd0, div_cancel}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; div_ready = 1'b0;
    @(negedge clk);
    chk("dflush_cancel_pulse", {63'd0, div_cancel}, 64'd0);
    chk("dflush_no_we", {63'd0, hi_we}, 64'd0);
    chk("dflush_idle", {63'd0, md_stallreq}, 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset during DIV_WAIT
    ex_md_op = 4'b0100; ex_src_a = 32'd9; ex_src_b = 32'd2;
    @(negedge clk);
    chk("rstmid_start", {63'd0, div_start}, 64'd1);
    @(posedge clk); #1;
    ex_md_op = 4'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_cancel", {63'd0, div_cancel}, 64'd0);
    chk("rstmid_stallreq", {63'd0, md_stallreq}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", {63'd0, md_stallreq}, 64'd0);
    chk("rstmid_operands", {md_op_a, md_op_b}, 64'd0);
    @(posedge clk); #1;

    // mult 0 * 9
    exp_q.push_back(64'd0);
    run_op(4'b0010, 32'd0, 32'd9, -1, 0, 0, ns, nm, nd, td, sg);
`ifdef MD_ZERO_SKIP_EN
    chk("zero_mul_start_pulses", nm, 0);
    chk("zero_done_cycle", td, 1);
`else
    chk("zero_mul_start_pulses", nm, 1);
    chk("zero_done_cycle", td, 3);
`endif
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MUL_LAT, default 2: multiplier result latency in cycles after mul_start, legal 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  `StallBus  pipeline stall vector; bit 3 = EX hold, `Stop/`NoStop encoding.
REQ-005 flush  input  1  abort in-flight operation.
REQ-006 ex_md_op  input  4  one-hot {div, divu, mult, multu} for the instruction in EX; 0 = none.
REQ-007 ex_src_a, ex_src_b  input  32 each  EX operands.
REQ-008 md_stallreq  output  1  stall request to the pipeline controller.
REQ-009 mul_start, div_start  output  1 each  one-cycle launch pulses; mul_signed, div_signed  output  1 each.
REQ-010 md_op_a, md_op_b  output  32 each  latched operands to both units.
REQ-011 mul_result  input  64;  div_ready  input  1;  div_quot, div_rem  input  32 each;  div_cancel  output  1.
REQ-012 hi_we, lo_we  output  1 each;  hi_wdata, lo_wdata  output  32 each  HI/LO results toward EX->MEM bus.

Function
REQ-013 FSM states IDLE, MUL_WAIT, DIV_WAIT, DONE.
REQ-014 IDLE with ex_md_op!=0 and flush=0: pulse mul_start or div_start for one cycle, latch operands, set signed flag from op, enter MUL_WAIT/DIV_WAIT.
REQ-015 md_stallreq = 1 combinationally in IDLE when ex_md_op!=0, and throughout MUL_WAIT and DIV_WAIT; 0 in DONE.
REQ-016 MUL_WAIT: 4-bit counter loaded with MUL_LAT; decrement each cycle; at 0 capture hi=mul_result[63:32], lo=mul_result[31:0], enter DONE; total start-to-DONE latency MUL_LAT+1 cycles.
REQ-017 DIV_WAIT: wait unbounded for div_ready; on the div_ready cycle capture hi=div_rem, lo=div_quot, enter DONE.
REQ-018 div/divu with ex_src_b==0: no div_start; next cycle DONE with hi=ex_src_a, lo=32'hFFFF_FFFF.
REQ-019 DONE: hi_we=lo_we=1 with captured data; hold while stall[3]==`Stop; return to IDLE on first cycle stall[3]==`NoStop.
REQ-020 Outside DONE: hi_we=lo_we=0, hi_wdata=lo_wdata=0.
REQ-021 A new op is never launched from DONE; back-to-back ops need one IDLE cycle.
REQ-022 flush in any state: next state IDLE, results cleared; in MUL_WAIT/DIV_WAIT assert div_cancel (DIV_WAIT only) for one cycle; flush overrides a coincident launch or div_ready.
REQ-023 div_ready outside DIV_WAIT is ignored; ex_md_op with >1 bit set treated as 0.
REQ-024 Operand registers change only on a launch cycle.

Reset
REQ-025 rst: state IDLE, counter 0, operands 0, captured HI/LO 0; all outputs 0 (md_stallreq 0 since ex_md_op ignored while rst=1).
REQ-026 rst mid-operation behaves as flush without div_cancel; div_cancel=0 during reset.
REQ-027 rst has priority over flush, stall and all inputs.

Configuration
REQ-028 Macro MD_ZERO_SKIP_EN: when defined, mult/multu with ex_src_a==0 or ex_src_b==0 issues no mul_start and enters DONE next cycle with hi=lo=0.
REQ-029 Without MD_ZERO_SKIP_EN, zero-operand multiplies follow REQ-016 unchanged.

Verification
REQ-030 multu a=32'h0001_0000, b=32'h0001_0000, MUL_LAT=2 -> mul_start 1 cycle, DONE 3 cycles later, hi=1, lo=0, md_stallreq high exactly 3 cycles.
REQ-031 div a=-7, b=2, div_ready after 10 cycles -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, div_signed=1, hi_we/lo_we 1 in DONE.
REQ-032 divu a=5, b=0 -> no div_start, DONE next cycle, hi=5, lo=32'hFFFF_FFFF.
REQ-033 DONE with stall[3]=`Stop for 4 cycles -> hi_we/lo_we and data held 4 cycles, IDLE after release.
REQ-034 flush in DIV_WAIT coincident with div_ready -> div_cancel pulse, IDLE next cycle, hi_we stays 0.
REQ-035 mult a=0, b=9 -> with MD_ZERO_SKIP_EN: no mul_start, DONE next cycle hi=lo=0; without: normal MUL_LAT path, hi=lo=0.
